// File: rtl/matrix_refresh_scheduler.sv
// Init, refresh and brightness sequencer for a 2x2 chain of MAX7219 drivers (16x16 display).
// Optional `DISPLAY_TEST_EN adds a test_mode input that shows a phase-toggling checkerboard.
module matrix_refresh_scheduler #(
  parameter logic [3:0]  BRIGHT_DEFAULT = 4'hF,
  parameter int unsigned PASS_GAP       = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0][15:0] frame,
  input  logic              frame_valid,
  output logic              frame_ready,
  input  logic              bright_req,
  input  logic [3:0]        bright_lvl,
`ifdef DISPLAY_TEST_EN
  input  logic              test_mode,
`endif
  output logic [63:0]       word_data,
  output logic              word_start,
  input  logic              word_done,
  output logic              init_done
);

  typedef enum logic [2:0] {S_INIT, S_ROW, S_END, S_BRIGHT, S_GAP} state_t;

  localparam logic [15:0] GAP_LAST = 16'((PASS_GAP == 0) ? 0 : PASS_GAP - 1);

  state_t            state, state_nx;
  logic              busy;
  logic [2:0]        init_idx;
  logic [2:0]        row;
  logic [15:0]       gap_cnt;
  logic [15:0][15:0] active, shadow;
  logic              frame_pend;
  logic [3:0]        lvl, bright_word_lvl;
  logic              bright_pend;
  logic              issue, done_ok;
  logic [15:0]       init_word;
  logic [63:0]       row_word, word_next;
  logic [3:0]        ri, ci;
`ifdef DISPLAY_TEST_EN
  logic              phase;
`endif

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    issue       = 1'b0;
    done_ok     = busy && word_done;
    state_nx    = state;
    frame_ready = !frame_pend && (state != S_END);
    case (state)
      S_INIT: begin
        issue = !busy;
        if (done_ok && init_idx == 3'd4) state_nx = S_ROW;
      end
      S_ROW: begin
        issue = !busy;
        if (done_ok && row == 3'd7) state_nx = S_END;
      end
      S_END: begin
        if (bright_pend)        state_nx = S_BRIGHT;
        else if (PASS_GAP == 0) state_nx = S_ROW;
        else                    state_nx = S_GAP;
      end
      S_BRIGHT: begin
        issue = !busy;
        if (done_ok) state_nx = (PASS_GAP == 0) ? S_ROW : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == GAP_LAST) state_nx = S_ROW;
      end
      default: state_nx = S_INIT;
    endcase
  end

  always_comb begin
    init_word = 16'h0C01;
    case (init_idx)
      3'd0:    init_word = 16'h0F00;
      3'd1:    init_word = 16'h0B07;
      3'd2:    init_word = 16'h0900;
      3'd3:    init_word = {12'h0A0, BRIGHT_DEFAULT};
      default: init_word = 16'h0C01;
    endcase
  end

  // Device d covers rows {d[1],row} and cols {d[0],c}; column 0 of a device lands in data bit 7.
  always_comb begin
    row_word = '0;
    ri       = '0;
    ci       = '0;
    for (int d = 0; d < 4; d++) begin
      row_word[d*16+8 +: 8] = 8'h01 + {5'd0, row};
      for (int c = 0; c < 8; c++) begin
        ri = {1'(d / 2), row};
        ci = {1'(d % 2), 3'(c)};
`ifdef DISPLAY_TEST_EN
        row_word[d*16 + 7 - c] = test_mode ? (ri[0] ^ ci[0] ^ phase) : active[ri][ci];
`else
        row_word[d*16 + 7 - c] = active[ri][ci];
`endif
      end
    end
  end

  always_comb begin
    word_next = row_word;
    case (state)
      S_INIT:   word_next = {4{init_word}};
      S_BRIGHT: word_next = {4{8'h0A, 4'h0, bright_word_lvl}};
      default:  word_next = row_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_INIT;
      busy            <= 1'b0;
      init_idx        <= '0;
      row             <= '0;
      gap_cnt         <= '0;
      word_start      <= 1'b0;
      word_data       <= '0;
      init_done       <= 1'b0;
      // NOTE: the frame buffers are reset too, so a reset always blanks the display.
      active          <= '0;
      shadow          <= '0;
      frame_pend      <= 1'b0;
      lvl             <= '0;
      bright_word_lvl <= '0;
      bright_pend     <= 1'b0;
`ifdef DISPLAY_TEST_EN
      phase           <= 1'b0;
`endif
    end else begin
      state      <= state_nx;
      word_start <= issue;
      if (issue) begin
        word_data <= word_next;
        busy      <= 1'b1;
      end else if (done_ok) begin
        busy <= 1'b0;
      end

      if (done_ok && state == S_INIT) begin
        init_idx <= init_idx + 3'd1;
        if (init_idx == 3'd4) init_done <= 1'b1;
      end
      if (done_ok && state == S_ROW) row <= row + 3'd1;

      gap_cnt <= (state == S_GAP) ? gap_cnt + 16'd1 : 16'd0;

      if (state == S_END && frame_pend) active <= shadow;
      if (frame_valid && frame_ready) begin
        shadow     <= frame;
        frame_pend <= 1'b1;
      end else if (state == S_END) begin
        frame_pend <= 1'b0;
      end

      // The level is frozen at END; requests from END onwards belong to the next pass.
      if (state == S_END) bright_word_lvl <= lvl;
      if (bright_req) begin
        lvl         <= bright_lvl;
        bright_pend <= 1'b1;
      end else if (state == S_END) begin
        bright_pend <= 1'b0;
      end
`ifdef DISPLAY_TEST_EN
      if (state == S_END) phase <= ~phase;
`endif
    end
  end

endmodule

// File: tb/tb_matrix_refresh_scheduler.sv
// Self-checking bench: a word-level display model plus a 4-cycle shifter stand-in.
module tb_matrix_refresh_scheduler;

  localparam int GAP = 10;

  logic              clk, reset;
  logic [15:0][15:0] frame;
  logic              frame_valid, frame_ready;
  logic              bright_req;
  logic [3:0]        bright_lvl;
  logic [63:0]       word_data;
  logic              word_start, word_done, init_done;
  logic              shifter_done, stray_done;

  assign word_done = shifter_done | stray_done;

  matrix_refresh_scheduler #(.BRIGHT_DEFAULT(4'hF), .PASS_GAP(GAP)) dut (
    .clk(clk), .reset(reset), .frame(frame), .frame_valid(frame_valid),
    .frame_ready(frame_ready), .bright_req(bright_req), .bright_lvl(bright_lvl),
`ifdef DISPLAY_TEST_EN
    .test_mode(1'b0),
`endif
    .word_data(word_data), .word_start(word_start), .word_done(word_done),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0, n_pass = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Shifter stand-in: done four cycles after each start, abandoned by reset.
  bit abort;
  initial begin
    shifter_done = 1'b0;
    forever begin
      @(negedge clk);
      if (word_start && !reset) begin
        abort = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(posedge clk);
          if (reset) abort = 1'b1;
        end
        if (!abort) begin
          #1 shifter_done = 1'b1;
          @(posedge clk);
          #1 shifter_done = 1'b0;
        end
      end
    end
  end

  // Model: words expected in order init x5, then per pass 8 rows + optional brightness word.
  // Latency from a done to the next start is 2 cycles, +1 for the END cycle, +GAP before row 0.
  logic [15:0]       init_tbl [5] = '{16'h0F00, 16'h0B07, 16'h0900, 16'h0A0F, 16'h0C01};
  logic [15:0][15:0] m_disp, m_shadow;
  logic [63:0]       m_cur, exp_w;
  logic [3:0]        m_lvl, m_blvl;
  logic              m_wait, m_init_done, m_fpend, m_bpend, m_bright_due, in_end, exp_ready;
  int                m_init_idx, m_row, m_kind, m_lat, m_last_done, m_end_at, m_last_end;
  int                pass_cnt = 0, r7_cnt = 0, cap_cnt = 0;
  logic [63:0]       row0_log [64], row7_log [64];
  logic [63:0]       init_log [$], bright_log [$];
  int                cap_cyc [$];

  function automatic logic [63:0] model_row(input int r);
    logic [63:0] w = '0;
    for (int d = 0; d < 4; d++) begin
      w[d*16+8 +: 8] = 8'(1 + r);
      for (int c = 0; c < 8; c++) w[d*16 + 7 - c] = m_disp[(d / 2) * 8 + r][(d % 2) * 8 + c];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_wait = 0; m_init_done = 0; m_fpend = 0; m_bpend = 0; m_bright_due = 0;
    m_disp = '0; m_shadow = '0; m_lvl = '0; m_blvl = '0;
    m_init_idx = 0; m_row = 0; m_kind = 0; m_lat = 2;
    m_last_done = -1; m_end_at = -1;
    init_log.delete();
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) model_reset();
    else begin
      in_end    = (cyc == m_end_at);
      exp_ready = !in_end && !m_fpend;
      check("init_done", {63'd0, init_done}, {63'd0, m_init_done});
      check("frame_ready", {63'd0, frame_ready}, {63'd0, exp_ready});
      if (m_wait) begin
        check("start_pulse", {63'd0, word_start}, 64'd0);
        check("word_hold", word_data, m_cur);
        if (word_done) begin
          m_wait = 0;
          m_last_done = cyc;
          case (m_kind)
            0: begin
              m_init_idx++;
              if (m_init_idx == 5) m_init_done = 1;
              m_lat = 2;
            end
            1: begin
              if (m_row < 7) begin m_row++; m_lat = 2; end
              else begin m_row = 0; m_end_at = cyc + 1; r7_cnt++; end
            end
            default: begin m_bright_due = 0; m_lat = 2 + GAP; end
          endcase
        end
      end else if (word_start) begin
        if (m_init_idx < 5) begin
          m_kind = 0; exp_w = {4{init_tbl[m_init_idx]}};
        end else if (m_bright_due) begin
          m_kind = 2; exp_w = {4{8'h0A, 4'h0, m_blvl}};
        end else begin
          m_kind = 1; exp_w = model_row(m_row);
        end
        check("word", word_data, exp_w);
        if (m_last_done >= 0) check("start_latency", 64'(cyc - m_last_done), 64'(m_lat));
        m_wait = 1;
        m_cur  = exp_w;
        if (m_kind == 0) init_log.push_back(word_data);
        if (m_kind == 2) bright_log.push_back(word_data);
        if (m_kind == 1 && m_row == 0) pass_cnt++;
        if (m_kind == 1 && m_row == 0 && pass_cnt < 64) row0_log[pass_cnt] = word_data;
        if (m_kind == 1 && m_row == 7 && pass_cnt < 64) row7_log[pass_cnt] = word_data;
      end
      if (in_end) begin
        m_last_end = cyc;
        if (m_fpend) begin m_disp = m_shadow; m_fpend = 0; end
        if (m_bpend) begin m_bright_due = 1; m_blvl = m_lvl; m_bpend = 0; m_lat = 3; end
        else m_lat = 3 + GAP;
      end
      if (bright_req) begin m_lvl = bright_lvl; m_bpend = 1; end
      if (frame_valid && exp_ready) begin
        m_shadow = frame; m_fpend = 1; cap_cnt++; cap_cyc.push_back(cyc);
      end
    end
  end

  task automatic wait_pass(input int p);
    for (int i = 0; i < 3000 && pass_cnt < p; i++) @(negedge clk);
    check("pass_reached", {63'd0, pass_cnt >= p}, 64'd1);
  endtask

  logic [63:0] init_exp [5] = '{64'h0F000F000F000F00, 64'h0B070B070B070B07,
                                64'h0900090009000900, 64'h0A0F0A0F0A0F0A0F,
                                64'h0C010C010C010C01};
  int base, p0;

  initial begin
    reset = 1'b1; frame = '0; frame_valid = 1'b0; bright_req = 1'b0; bright_lvl = '0;
    stray_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_word_start", {63'd0, word_start}, 64'd0);
    check("rst_word_data", word_data, 64'd0);
    check("rst_init_done", {63'd0, init_done}, 64'd0);
    check("rst_frame_ready", {63'd0, frame_ready}, 64'd1);

    for (int i = 0; i < 300 && !init_done; i++) @(negedge clk);
    check("init_done_reached", {63'd0, init_done}, 64'd1);
    check("init_count", 64'(init_log.size()), 64'd5);
    for (int i = 0; i < 5 && i < init_log.size(); i++) check("init_word_lit", init_log[i], init_exp[i]);

    // Corner pixels: shown in the pass after the one they arrive in.
    wait_pass(1);
    @(posedge clk); #1;
    frame = '0; frame[0][0] = 1'b1; frame[15][15] = 1'b1; frame_valid = 1'b1;
    @(posedge clk); #1 frame_valid = 1'b0; frame = '0;
    wait_pass(3);
    check("corner_row0", row0_log[2], 64'h0100_0100_0100_0180);
    check("corner_row7", row7_log[2], 64'h0801_0800_0800_0800);

    // Valid held for two frames: the second is taken only after the next END.
    base = cap_cnt;
    @(posedge clk); #1;
    for (int r = 0; r < 16; r++) frame[r] = 16'h00FF;
    frame_valid = 1'b1;
    for (int i = 0; i < 600 && cap_cnt < base + 2; i++) begin
      @(posedge clk); #1;
      if (cap_cnt == base + 1) for (int r = 0; r < 16; r++) frame[r] = 16'($urandom);
    end
    frame_valid = 1'b0;
    check("two_captures", 64'(cap_cnt - base), 64'd2);
    if (cap_cyc.size() >= base + 2) check("cap_after_end", 64'(cap_cyc[base + 1] - m_last_end), 64'd1);
    wait_pass(5);
    check("frame_b_row0", row0_log[4], 64'h0100_01FF_0100_01FF);

    // Two brightness requests in one pass collapse to the last level.
    repeat (3) @(posedge clk);
    #1 bright_req = 1'b1; bright_lvl = 4'd3;
    @(posedge clk); #1 bright_req = 1'b0;
    repeat (4) @(posedge clk);
    #1 bright_req = 1'b1; bright_lvl = 4'd5;
    @(posedge clk); #1 bright_req = 1'b0;
    wait_pass(6);
    check("bright_count", 64'(bright_log.size()), 64'd1);
    if (bright_log.size() > 0) check("bright_word", bright_log[0], 64'h0A05_0A05_0A05_0A05);

    // Stray done during the gap must be ignored.
    base = r7_cnt;
    for (int i = 0; i < 600 && r7_cnt == base; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 stray_done = 1'b1;
    @(posedge clk); #1 stray_done = 1'b0;

    // Reset in the middle of row word 3.
    wait_pass(8);
    for (int i = 0; i < 600 && !(m_wait && m_kind == 1 && m_row == 3); i++) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_word_start", {63'd0, word_start}, 64'd0);
    check("mid_rst_frame_ready", {63'd0, frame_ready}, 64'd1);
    check("mid_rst_init_done", {63'd0, init_done}, 64'd0);
    p0 = pass_cnt;
    wait_pass(p0 + 1);
    if (init_log.size() > 0) check("reinit_first", init_log[0], 64'h0F000F000F000F00);
    check("cleared_row0", row0_log[p0 + 1], 64'h0100_0100_0100_0100);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
